// File: rtl/salamander_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : salamander_pkg
//  Description : Shared definitions for the Salamander-4 datapath: opcode
//                constants (common to ALU and control), control FSM state
//                enum and instruction field helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package salamander_pkg;

    // Instruction word layout: [11:8] opcode, [7:0] address / jump target
    localparam int c_INSTR_W = 12;
    localparam int c_OPC_MSB = 11;
    localparam int c_OPC_LSB = 8;
    localparam int c_ARG_MSB = 7;
    localparam int c_ARG_LSB = 0;

    typedef logic [3:0] opcode_t;

    localparam opcode_t c_OP_ADD = 4'h0;
    localparam opcode_t c_OP_SUB = 4'h1;
    localparam opcode_t c_OP_AND = 4'h2;
    localparam opcode_t c_OP_OR  = 4'h3;
    localparam opcode_t c_OP_XOR = 4'h4;
    localparam opcode_t c_OP_NOT = 4'h5;
    localparam opcode_t c_OP_LD  = 4'h6;
    localparam opcode_t c_OP_ST  = 4'h7;
    localparam opcode_t c_OP_INC = 4'h8;
    localparam opcode_t c_OP_DEC = 4'h9;
    localparam opcode_t c_OP_SHL = 4'hA;
    localparam opcode_t c_OP_SHR = 4'hB;
    localparam opcode_t c_OP_HLT = 4'hC;
    localparam opcode_t c_OP_JZ  = 4'hD;
    localparam opcode_t c_OP_JNZ = 4'hE;
    localparam opcode_t c_OP_NOP = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    function automatic opcode_t opcode_of(input logic [c_INSTR_W-1:0] instr);
        return instr[c_OPC_MSB:c_OPC_LSB];
    endfunction

    function automatic logic [7:0] arg_of(input logic [c_INSTR_W-1:0] instr);
        return instr[c_ARG_MSB:c_ARG_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bus bundle between the control unit and its environment:
//                program memory port, data memory port and ALU drive/return.
//                master = control unit side, slave = memories + ALU side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_if #(
    parameter int SIZE = 8,
    parameter int AW   = 8
);
    logic [AW-1:0]   prog_addr;
    logic            prog_re;
    logic [11:0]     prog_data;

    logic [AW-1:0]   data_addr;
    logic            data_re;
    logic [SIZE-1:0] data_rdata;
    logic            data_we;
    logic [SIZE-1:0] data_wdata;

    logic            alu_ce;
    logic [3:0]      alu_op;
    logic [SIZE-1:0] alu_left;
    logic [SIZE-1:0] alu_right;
    logic            alu_carry_in;
    logic            alu_carry_out;
    logic [SIZE-1:0] alu_result;

    modport master (
        output prog_addr, prog_re,
        input  prog_data,
        output data_addr, data_re, data_we, data_wdata,
        input  data_rdata,
        output alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
        input  alu_carry_out, alu_result
    );

    modport slave (
        input  prog_addr, prog_re,
        output prog_data,
        input  data_addr, data_re, data_we, data_wdata,
        output data_rdata,
        input  alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
        output alu_carry_out, alu_result
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational opcode classifier.
//  Ports       : opcode        in  4 - instruction opcode
//                needs_mem     out 1 - operand fetched from data memory
//                writes_acc    out 1 - result committed to ACC / zero flag
//                writes_mem    out 1 - result written to data memory
//                is_jump       out 1 - conditional jump (JZ / JNZ)
//                is_halt       out 1 - HLT
//                updates_carry out 1 - carry flag takes ALU carry_out
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import salamander_pkg::*;
(
    input  opcode_t opcode,
    output logic    needs_mem,
    output logic    writes_acc,
    output logic    writes_mem,
    output logic    is_jump,
    output logic    is_halt,
    output logic    updates_carry
);
    always_comb begin
        needs_mem     = 1'b0;
        writes_acc    = 1'b0;
        writes_mem    = 1'b0;
        is_jump       = 1'b0;
        is_halt       = 1'b0;
        updates_carry = 1'b0;
        case (opcode)
            c_OP_ADD, c_OP_SUB: begin
                needs_mem     = 1'b1;
                writes_acc    = 1'b1;
                updates_carry = 1'b1;
            end
            c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_LD: begin
                needs_mem  = 1'b1;
                writes_acc = 1'b1;
            end
            c_OP_NOT, c_OP_INC, c_OP_DEC, c_OP_SHL, c_OP_SHR: begin
                writes_acc = 1'b1;
            end
            c_OP_ST:            writes_mem = 1'b1;
            c_OP_HLT:           is_halt    = 1'b1;
            c_OP_JZ, c_OP_JNZ:  is_jump    = 1'b1;
            c_OP_NOP: begin
            end
            default: begin
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Salamander-4 sequencing engine. Fetches 12-bit instructions,
//                decodes them, fetches memory operands, drives the ALU and
//                commits results to ACC, flags, data memory or PC.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                run           - fetch enable (sampled in FETCH only)
//                bus (master)  - program memory, data memory and ALU bundle
//                acc, pc       - accumulator and program counter
//                carry_flag, zero_flag - status flags
//                halted        - high while in HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import salamander_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int AW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    control_unit_if.master  bus,
    output logic [SIZE-1:0] acc,
    output logic [AW-1:0]   pc,
    output logic            carry_flag,
    output logic            zero_flag,
    output logic            halted
);
    state_t          r_state;
    logic [11:0]     r_ir;
    logic [SIZE-1:0] r_acc;
    logic [AW-1:0]   r_pc;
    logic            r_carry;
    logic            r_zero;

    opcode_t         w_opcode;
    logic            w_needs_mem;
    logic            w_writes_acc;
    logic            w_writes_mem;
    logic            w_is_jump;
    logic            w_is_halt;
    logic            w_updates_carry;
    logic            w_jump_taken;
    logic [AW-1:0]   w_target;

    // In DECODE the instruction is still on the program bus (IR loads at the
    // end of that cycle); afterwards the opcode comes from IR.
    assign w_opcode = (r_state == ST_DECODE) ? opcode_of(bus.prog_data)
                                             : opcode_of(r_ir);
    assign w_target = AW'(arg_of(bus.prog_data));

    instr_decode u_decode (
        .opcode        (w_opcode),
        .needs_mem     (w_needs_mem),
        .writes_acc    (w_writes_acc),
        .writes_mem    (w_writes_mem),
        .is_jump       (w_is_jump),
        .is_halt       (w_is_halt),
        .updates_carry (w_updates_carry)
    );

    // Flag tested is the committed one: the previous EXEC updated it already.
    assign w_jump_taken = w_is_jump &&
                          ((w_opcode == c_OP_JZ) ? r_zero : !r_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= '0;
            r_acc   <= '0;
            r_pc    <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (run) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir <= bus.prog_data;
                    r_pc <= w_jump_taken ? w_target : r_pc + 1'b1;
                    if (w_is_halt)                         r_state <= ST_HALT;
                    else if (w_needs_mem)                  r_state <= ST_MEM;
                    else if (w_writes_acc || w_writes_mem) r_state <= ST_EXEC;
                    else                                   r_state <= ST_FETCH;
                end
                ST_MEM: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_writes_acc) begin
                        r_acc  <= bus.alu_result;
                        r_zero <= (bus.alu_result == '0);
                    end
                    if (w_updates_carry) r_carry <= bus.alu_carry_out;
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobes and ALU drive are decoded from state; rst masks them so that an
    // abandoned instruction never issues a write in the reset cycle.
    always_comb begin
        bus.prog_addr  = r_pc;
        bus.prog_re    = 1'b0;
        bus.data_addr  = AW'(arg_of(r_ir));
        bus.data_re    = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_wdata = '0;
        bus.alu_ce     = 1'b0;
        bus.alu_op     = '0;
        bus.alu_right  = '0;
        if (!rst) begin
            case (r_state)
                ST_FETCH: bus.prog_re = run;
                ST_MEM:   bus.data_re = 1'b1;
                ST_EXEC: begin
                    bus.alu_ce    = 1'b1;
                    bus.alu_op    = opcode_of(r_ir);
                    bus.alu_right = w_needs_mem ? bus.data_rdata : '0;
                    if (w_writes_mem) begin
                        bus.data_we    = 1'b1;
                        bus.data_wdata = bus.alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.alu_left     = r_acc;
    assign bus.alu_carry_in = 1'b0;

    assign acc        = r_acc;
    assign pc         = r_pc;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign halted     = (r_state == ST_HALT);
endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit with program/data
//                memory models, a behavioural ALU and an instruction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
    import salamander_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       carry_flag, zero_flag, halted;

    control_unit_if #(.SIZE(8), .AW(8)) bus ();

    control_unit #(.SIZE(8), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .bus        (bus),
        .acc        (acc),
        .pc         (pc),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // ---------------- environment: memories and ALU ----------------
    logic [11:0] pmem  [256];
    logic [7:0]  dinit [256];
    logic [7:0]  dmem  [256];
    bit          mem_load = 1'b0;
    int          we_cnt = 0;
    logic [7:0]  we_addr = '0;
    logic [7:0]  we_data = '0;
    logic [8:0]  alu_t;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) dmem[i] <= dinit[i];
        end else if (bus.data_we) begin
            dmem[bus.data_addr] <= bus.data_wdata;
        end
        if (bus.prog_re) bus.prog_data  <= pmem[bus.prog_addr];
        if (bus.data_re) bus.data_rdata <= dmem[bus.data_addr];
    end

    always @(posedge clk) begin
        if (bus.data_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.data_addr;
            we_data <= bus.data_wdata;
        end
    end

    // SUB carry_out is the borrow; shifts return the bit shifted out.
    always_comb begin
        alu_t = '0;
        case (bus.alu_op)
            c_OP_ADD: alu_t = {1'b0, bus.alu_left} + {1'b0, bus.alu_right};
            c_OP_SUB: alu_t = {1'b0, bus.alu_left} - {1'b0, bus.alu_right};
            c_OP_AND: alu_t = {1'b0, bus.alu_left & bus.alu_right};
            c_OP_OR:  alu_t = {1'b0, bus.alu_left | bus.alu_right};
            c_OP_XOR: alu_t = {1'b0, bus.alu_left ^ bus.alu_right};
            c_OP_NOT: alu_t = {1'b0, ~bus.alu_left};
            c_OP_LD:  alu_t = {1'b0, bus.alu_right};
            c_OP_ST:  alu_t = {1'b0, bus.alu_left};
            c_OP_INC: alu_t = {1'b0, bus.alu_left} + 9'd1;
            c_OP_DEC: alu_t = {1'b0, bus.alu_left} - 9'd1;
            c_OP_SHL: alu_t = {bus.alu_left, 1'b0};
            c_OP_SHR: alu_t = {bus.alu_left[0], 1'b0, bus.alu_left[7:1]};
            default:  alu_t = '0;
        endcase
    end
    assign bus.alu_result    = alu_t[7:0];
    assign bus.alu_carry_out = alu_t[8];

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.prog_re === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL fetch_timeout: no prog_re within 10 cycles (t=%0t)", $time);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; mem_load = 1'b1;
        tick(); tick();
        rst = 1'b0; mem_load = 1'b0;
        tick();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            pmem[i]  = {c_OP_HLT, 8'h00};
            dinit[i] = 8'h00;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] acc_in;
        logic [7:0] opnd;
        logic [7:0] exp_acc;
        bit         exp_c;
        bit         exp_z;
        int         exp_cyc;
    } vec_t;
    vec_t vecs [15];

    // ---------------- randomized run against reference model ----------------
    task automatic random_test(input int n_instr);
        logic [7:0] md [256];
        logic [7:0] m_acc, m_pc, a;
        logic [3:0] op;
        bit         m_c, m_z, wr, ok;
        int         m_cyc, t_prev, bad, v;
        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == c_OP_HLT) op = c_OP_NOP;
            pmem[i]  = {op, 8'($urandom_range(0, 255))};
            dinit[i] = 8'($urandom_range(0, 255));
            md[i]    = dinit[i];
        end
        do_reset();
        m_acc = 0; m_pc = 0; m_c = 0; m_z = 0; m_cyc = 0;
        run = 1'b1; #1;
        t_prev = cyc;
        for (int k = 0; k < n_instr; k++) begin
            if (k > 0) begin
                wait_fetch(ok);
                if (!ok) return;
            end
            check("rand_step", {pc, acc, carry_flag, zero_flag, 8'(cyc - t_prev)},
                               {m_pc, m_acc, m_c, m_z, 8'(m_cyc)});
            t_prev = cyc;
            op = pmem[m_pc][11:8];
            a  = pmem[m_pc][7:0];
            m_pc = m_pc + 8'd1;
            wr = 1'b1;
            m_cyc = 3;
            case (op)
                c_OP_ADD: begin v = int'(m_acc) + int'(md[a]); m_c = (v > 255);
                                m_acc = 8'(v); m_cyc = 4; end
                c_OP_SUB: begin m_c = (m_acc < md[a]); m_acc = m_acc - md[a]; m_cyc = 4; end
                c_OP_AND: begin m_acc = m_acc & md[a]; m_cyc = 4; end
                c_OP_OR:  begin m_acc = m_acc | md[a]; m_cyc = 4; end
                c_OP_XOR: begin m_acc = m_acc ^ md[a]; m_cyc = 4; end
                c_OP_LD:  begin m_acc = md[a]; m_cyc = 4; end
                c_OP_NOT: m_acc = ~m_acc;
                c_OP_INC: m_acc = m_acc + 8'd1;
                c_OP_DEC: m_acc = m_acc - 8'd1;
                c_OP_SHL: m_acc = m_acc << 1;
                c_OP_SHR: m_acc = m_acc >> 1;
                c_OP_ST:  begin md[a] = m_acc; wr = 1'b0; end
                c_OP_JZ:  begin if (m_z) m_pc = a; wr = 1'b0; m_cyc = 2; end
                c_OP_JNZ: begin if (!m_z) m_pc = a; wr = 1'b0; m_cyc = 2; end
                default:  begin wr = 1'b0; m_cyc = 2; end
            endcase
            if (wr) m_z = (m_acc == 8'h00);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== md[i]) bad++;
        check("rand_dmem_mismatches", 64'(bad), 64'd0);
        run = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int t0, t1, w0, cnt;

        vecs[0]  = '{c_OP_ADD, 8'h05, 8'hFF, 8'h04, 1'b1, 1'b0, 4};
        vecs[1]  = '{c_OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 4};
        vecs[2]  = '{c_OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 4};
        vecs[3]  = '{c_OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 4};
        vecs[4]  = '{c_OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 4};
        vecs[5]  = '{c_OP_OR,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 4};
        vecs[6]  = '{c_OP_XOR, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 4};
        vecs[7]  = '{c_OP_NOT, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 3};
        vecs[8]  = '{c_OP_INC, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 3};
        vecs[9]  = '{c_OP_DEC, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 3};
        vecs[10] = '{c_OP_SHL, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 3};
        vecs[11] = '{c_OP_SHR, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 3};
        vecs[12] = '{c_OP_ST,  8'hA5, 8'h3C, 8'hA5, 1'b0, 1'b0, 3};
        vecs[13] = '{c_OP_NOP, 8'h33, 8'h00, 8'h33, 1'b0, 1'b0, 2};
        vecs[14] = '{c_OP_LD,  8'h77, 8'h00, 8'h00, 1'b0, 1'b1, 4};

        // Reset state, with run high to show the strobes are masked.
        clear_mem();
        rst = 1'b1; run = 1'b1; mem_load = 1'b1;
        tick(); tick();
        check("reset_outputs",
              {bus.prog_re, bus.data_re, bus.data_we, bus.alu_ce, bus.alu_op,
               bus.alu_right, bus.alu_left, bus.alu_carry_in, acc, pc,
               carry_flag, zero_flag, halted}, 64'd0);
        rst = 1'b0; run = 1'b0; mem_load = 1'b0;
        tick(); tick();
        check("idle_no_fetch", {bus.prog_re, pc, halted}, 64'd0);

        // Table: LD 0x80 (acc_in), <op> 0x81 (opnd), HLT
        for (int i = 0; i < 15; i++) begin
            clear_mem();
            pmem[0] = {c_OP_LD, 8'h80};
            pmem[1] = {vecs[i].op, 8'h81};
            dinit[8'h80] = vecs[i].acc_in;
            dinit[8'h81] = vecs[i].opnd;
            do_reset();
            run = 1'b1; #1;
            wait_fetch(ok);
            t0 = cyc;
            if (ok) wait_fetch(ok);
            if (ok) begin
                check($sformatf("vec%0d_acc_c_z_cyc", i),
                      {acc, carry_flag, zero_flag, 8'(cyc - t0)},
                      {vecs[i].exp_acc, vecs[i].exp_c, vecs[i].exp_z, 8'(vecs[i].exp_cyc)});
                if (vecs[i].op == c_OP_ST)
                    check("vec_st_dmem", 64'(dmem[8'h81]), 64'(vecs[i].exp_acc));
            end
            run = 1'b0;
        end

        // LD 0x10 ; ADD 0x11 : 8 cycles total
        clear_mem();
        pmem[0] = {c_OP_LD, 8'h10}; pmem[1] = {c_OP_ADD, 8'h11};
        dinit[8'h10] = 8'h05; dinit[8'h11] = 8'hFF;
        do_reset();
        run = 1'b1; #1;
        t0 = cyc;
        wait_fetch(ok);
        if (ok) wait_fetch(ok);
        if (ok) check("ld_add_seq", {acc, carry_flag, zero_flag, 8'(cyc - t0)},
                      {8'h04, 1'b1, 1'b0, 8'd8});
        run = 1'b0;

        // DEC -> JZ taken -> JNZ not taken
        clear_mem();
        pmem[0] = {c_OP_LD, 8'h50}; pmem[1] = {c_OP_DEC, 8'h00};
        pmem[2] = {c_OP_JZ, 8'h20}; pmem[8'h20] = {c_OP_JNZ, 8'h30};
        dinit[8'h50] = 8'h01;
        do_reset();
        run = 1'b1; #1;
        wait_fetch(ok);
        if (ok) wait_fetch(ok);
        t0 = cyc;
        if (ok) wait_fetch(ok);
        if (ok) check("jz_taken", {pc, zero_flag, acc, 8'(cyc - t0)},
                      {8'h20, 1'b1, 8'h00, 8'd2});
        if (ok) wait_fetch(ok);
        if (ok) check("jnz_not_taken", 64'(pc), 64'h21);
        run = 1'b0;

        // ST with ACC=0xA5, carry=1 beforehand (LD 0x04 ; SUB 0x5F borrows)
        clear_mem();
        pmem[0] = {c_OP_LD, 8'h10}; pmem[1] = {c_OP_SUB, 8'h11};
        pmem[2] = {c_OP_ST, 8'h40};
        dinit[8'h10] = 8'h04; dinit[8'h11] = 8'h5F; dinit[8'h40] = 8'h00;
        do_reset();
        w0 = we_cnt;
        run = 1'b1; #1;
        wait_fetch(ok);
        if (ok) wait_fetch(ok);
        t0 = cyc;
        if (ok) wait_fetch(ok);
        if (ok) begin
            check("st_regs", {acc, carry_flag, zero_flag, 8'(cyc - t0)},
                  {8'hA5, 1'b1, 1'b0, 8'd3});
            check("st_write", {32'(we_cnt - w0), we_addr, we_data, dmem[8'h40]},
                  {32'd1, 8'h40, 8'hA5, 8'hA5});
        end
        run = 1'b0;

        // PC wrap: JNZ 0xFF (zero=0 after reset), NOP at 0xFF
        clear_mem();
        pmem[0] = {c_OP_JNZ, 8'hFF}; pmem[8'hFF] = {c_OP_NOP, 8'h00};
        do_reset();
        run = 1'b1; #1;
        wait_fetch(ok);
        if (ok) check("jump_to_ff", 64'(pc), 64'hFF);
        if (ok) wait_fetch(ok);
        if (ok) check("pc_wrap", 64'(pc), 64'h00);
        run = 1'b0;

        // HLT: halted from the cycle after DECODE, no fetch, rst recovers
        clear_mem();
        pmem[0] = {c_OP_NOP, 8'h00}; pmem[1] = {c_OP_HLT, 8'h00};
        do_reset();
        run = 1'b1; #1;
        wait_fetch(ok);
        if (ok) begin
            tick();
            check("hlt_decode_not_halted", 64'(halted), 64'd0);
            tick();
            check("hlt_halted", {halted, pc}, {1'b1, 8'h02});
            cnt = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (bus.prog_re !== 1'b0) cnt++;
            end
            check("hlt_no_fetch", 64'(cnt), 64'd0);
            rst = 1'b1;
            tick();
            check("hlt_reset", {pc, halted, bus.prog_re}, 64'd0);
            rst = 1'b0;
        end
        run = 1'b0;

        // rst during EXEC of ST: no write, back to FETCH with ACC=0
        clear_mem();
        pmem[0] = {c_OP_LD, 8'h10}; pmem[1] = {c_OP_ST, 8'h61};
        dinit[8'h10] = 8'h77; dinit[8'h61] = 8'h11;
        do_reset();
        run = 1'b1; #1;
        wait_fetch(ok);
        if (ok) begin
            tick(); tick();
            check("exec_st_active", {bus.alu_ce, bus.data_we, bus.data_addr}, {2'b11, 8'h61});
            w0 = we_cnt;
            rst = 1'b1; #1;
            check("rst_masks_we", {bus.data_we, bus.alu_ce}, 64'd0);
            tick();
            check("rst_exec_regs", {acc, pc, 32'(we_cnt - w0)}, 64'd0);
            rst = 1'b0; #1;
            check("rst_exec_fetch", {bus.prog_re, bus.prog_addr, dmem[8'h61]},
                  {1'b1, 8'h00, 8'h11});
        end
        run = 1'b0;

        random_test(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Sequencing engine for the Salamander-4 datapath. Fetches 12-bit instructions from program memory, decodes them, fetches memory operands, drives the ALU (`CE`, `OP_CODE`, operands, `carry_in`), and commits results to the accumulator, flags, data memory or PC. It is the initiating side of the ALU interface and sits between the program/data memories and the ALU instance.

## Interface
Parameters:
- `SIZE`, 8, data and accumulator width; must match the ALU `SIZE`.
- `AW`, 8, program and data address width; also the PC width.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: fetch enable, sampled only in FETCH.
- `prog_addr` out AW: program memory address.
- `prog_re` out 1: program read strobe.
- `prog_data` in 12: instruction word, valid the cycle after `prog_re`.
- `data_addr` out AW: data memory address.
- `data_re` out 1: data read strobe.
- `data_rdata` in SIZE: read data, valid the cycle after `data_re`.
- `data_we` out 1: data write strobe.
- `data_wdata` out SIZE: write data.
- `alu_ce` out 1: ALU `CE`.
- `alu_op` out 4: ALU `OP_CODE`.
- `alu_left` out SIZE: ALU `left_operand`; always equals ACC.
- `alu_right` out SIZE: ALU `right_operand`.
- `alu_carry_in` out 1: ALU `carry_in`; tied to 0.
- `alu_carry_out` in 1: ALU `carry_out`.
- `alu_result` in SIZE: ALU `op_out`.
- `acc` out SIZE: accumulator.
- `pc` out AW: program counter.
- `carry_flag`, `zero_flag` out 1: status flags.
- `halted` out 1: high in HALT.

## Operation
- Instruction format: `[11:8]` is the opcode, `[7:0]` is the operand address or jump target.
- ALU zero flag is ignored. `zero_flag` is computed here as `alu_result == 0`.
- FSM states: FETCH, DECODE, MEM, EXEC, HALT. Reset state is FETCH.
- FETCH:
  - `prog_addr`=PC.
  - If `run`: `prog_re`=1, go to DECODE.
  - Otherwise stay in FETCH with no strobe.
- DECODE:
  - IR <= `prog_data`; PC <= PC+1, wrapping 255->0.
  - JZ taken when `zero_flag`=1; JNZ taken when `zero_flag`=0. A taken jump loads PC <= target instead of PC+1.
  - Next state: HLT -> HALT; JZ/JNZ/NOP -> FETCH; ADD/SUB/AND/OR/XOR/LD -> MEM; all others -> EXEC.
- MEM: `data_addr`=IR[7:0], `data_re`=1, go to EXEC.
- EXEC:
  - `alu_ce`=1, `alu_op`=IR opcode.
  - `alu_right`=`data_rdata` for memory ops, 0 otherwise.
  - ST: `data_we`=1, `data_addr`=IR[7:0], `data_wdata`=`alu_result` (OP_ST passes ACC through); ACC and flags unchanged.
  - All other ops: ACC <= `alu_result`; `zero_flag` <= (`alu_result`==0).
  - ADD/SUB only: `carry_flag` <= `alu_carry_out`; other ops leave `carry_flag` unchanged.
  - Go to FETCH.
- HALT: absorbing; only `rst` exits. `halted`=1 and no strobes are driven.
- All strobes (`prog_re`, `data_re`, `data_we`, `alu_ce`) are decoded from state and forced low while `rst`=1.

## Timing
- Reset values: ACC=0, PC=0, IR=0, both flags=0, state=FETCH. `halted`, all strobes and all ALU-drive outputs are 0.
- Cycles per instruction, FETCH to next FETCH:
  - Memory-operand ops: 4.
  - Register ops and ST: 3.
  - JZ/JNZ/NOP: 2.
  - HLT: 2, then HALT with `halted` high from the following cycle.
- Writes occur exactly in the EXEC cycle; ACC/flag updates are visible the cycle after EXEC.
- JZ/JNZ test the flag value from before DECODE; the previous EXEC has already committed it.
- `rst` asserted in any state abandons the instruction; no write is issued in that cycle.
- `run` deasserted mid-instruction is ignored; the instruction completes.

## Structure
- `salamander_pkg` holds the opcode constants used by both ALU and control:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LD=6, ST=7.
  - INC=8, DEC=9, SHL=A, SHR=B, HLT=C, JZ=D, JNZ=E, NOP=F.
- The package also holds the FSM state enum and the instruction field slices.
- Sub-module `instr_decode` (combinational): opcode in -> `needs_mem`, `writes_acc`, `writes_mem`, `is_jump`, `is_halt`, `updates_carry`.

## Test plan
- Reset, then `run`=1 with program `LD 0x10` (data[0x10]=0x05), `ADD 0x11` (data[0x11]=0xFF):
  - ACC=0x04, `carry_flag`=1, `zero_flag`=0.
  - 8 cycles total.
- ACC=0x01, `DEC` then `JZ 0x20`: `zero_flag`=1, PC=0x20 after DECODE; `JNZ 0x30` at 0x20 is not taken, PC=0x21.
- ACC=0xA5, `ST 0x40`: single-cycle `data_we` with `data_addr`=0x40, `data_wdata`=0xA5; ACC and flags unchanged.
- PC=0xFF with NOP: PC wraps to 0x00.
- `HLT`: `halted`=1, no further `prog_re` over 20 cycles; `rst` returns PC=0 and `halted`=0.
- `rst` pulsed during the EXEC of `ST`: `data_we` stays 0 in that cycle; state=FETCH and ACC=0 next cycle.
